// File: rtl/icache_miss_fill_fsm_i_0.sv
// Instruction L1 miss handler for core 0: captures the victim way, arbitrates for the
// common bus, fetches one line, writes it into the victim way, and reports the accessed way to the LRU.
module icache_miss_fill_fsm_i_0 #(
  parameter int ADDRESSSIZE = 32,
  parameter int WAY_W       = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   PrRd,
  input  logic [ADDRESSSIZE-1:0] Address,
  input  logic                   Hit,
  input  logic [WAY_W-1:0]       Hit_way,
  input  logic [WAY_W-1:0]       LRU_replacement_proc,
  output logic [WAY_W-1:0]       Blk_accessed,
  output logic                   Blk_access_valid,
  output logic                   CPU_stall,
  output logic                   Com_Bus_Req,
  input  logic                   Com_Bus_Gnt,
  output logic [ADDRESSSIZE-1:0] Address_Com,
  output logic                   Mem_Rd,
  input  logic                   Mem_ready,
  input  logic [ADDRESSSIZE-1:0] Data_Bus_Com,
  output logic                   Fill_we,
  output logic [WAY_W-1:0]       Fill_way,
  output logic [ADDRESSSIZE-1:0] Fill_addr,
  output logic [ADDRESSSIZE-1:0] Fill_data,
  output logic                   Bus_error
);

  // One bus beat fills a whole line, so the block offset is the byte offset within a data word.
  localparam int OFFSET_W = $clog2(ADDRESSSIZE / 8);
  localparam int CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ARB, RD, FILL, DONE} state_t;

  state_t                 state, state_next;
  logic [CNT_W-1:0]       cnt;
  logic [ADDRESSSIZE-1:0] miss_addr;
  logic [WAY_W-1:0]       victim;
  logic [ADDRESSSIZE-1:0] fill_data_q;
  logic                   miss;

  assign miss = PrRd && !Hit;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      miss_addr   <= '0;
      victim      <= '0;
      fill_data_q <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && miss) begin
        miss_addr <= Address;
        victim    <= LRU_replacement_proc;
      end
      // Saturating RD-cycle counter; cleared whenever the FSM is outside RD.
      if (state == RD) begin
        if (cnt != CNT_LAST) cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
      end
      if (state == RD && Mem_ready) fill_data_q <= Data_Bus_Com;
    end
  end

  // NOTE: every output and the next state get a default first, so no path infers a latch.
  always_comb begin
    state_next       = state;
    Blk_accessed     = '0;
    Blk_access_valid = 1'b0;
    CPU_stall        = 1'b0;
    Com_Bus_Req      = 1'b0;
    Address_Com      = '0;
    Mem_Rd           = 1'b0;
    Fill_we          = 1'b0;
    Fill_way         = '0;
    Fill_addr        = '0;
    Fill_data        = '0;
    Bus_error        = 1'b0;
    unique case (state)
      IDLE: begin
        if (PrRd && Hit) begin
          Blk_accessed     = Hit_way;
          Blk_access_valid = 1'b1;
        end else if (miss) begin
          CPU_stall  = 1'b1;
          state_next = ARB;
        end
      end
      ARB: begin
        Com_Bus_Req = 1'b1;
        CPU_stall   = 1'b1;
        if (Com_Bus_Gnt) state_next = RD;
      end
      RD: begin
        Com_Bus_Req = 1'b1;
        Mem_Rd      = 1'b1;
        CPU_stall   = 1'b1;
        Address_Com = {miss_addr[ADDRESSSIZE-1:OFFSET_W], {OFFSET_W{1'b0}}};
        // Data arriving on the last allowed cycle still completes the fill.
        if (Mem_ready) begin
          state_next = FILL;
        end else if (cnt == CNT_LAST) begin
          Bus_error  = 1'b1;
          state_next = IDLE;
        end
      end
      FILL: begin
        CPU_stall  = 1'b1;
        Fill_we    = 1'b1;
        Fill_way   = victim;
        Fill_addr  = miss_addr;
        Fill_data  = fill_data_q;
        state_next = DONE;
      end
      DONE: begin
        Blk_accessed     = victim;
        Blk_access_valid = 1'b1;
        state_next       = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_icache_miss_fill_fsm_i_0.sv
// Directed bench for the I-cache miss/fill sequencer: a per-cycle vector table plus
// hand-built sequences for grant delay, timeout boundary and reset mid-miss.
module tb_icache_miss_fill_fsm_i_0;

  localparam int AW = 32;
  localparam int WW = 2;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          PrRd, Hit, Com_Bus_Gnt, Mem_ready;
  logic [AW-1:0] Address, Data_Bus_Com;
  logic [WW-1:0] Hit_way, LRU_replacement_proc;
  logic [WW-1:0] Blk_accessed, Fill_way;
  logic          Blk_access_valid, CPU_stall, Com_Bus_Req, Mem_Rd, Fill_we, Bus_error;
  logic [AW-1:0] Address_Com, Fill_addr, Fill_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  icache_miss_fill_fsm_i_0 #(.ADDRESSSIZE(AW), .WAY_W(WW), .TIMEOUT(TO)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .PrRd                (PrRd),
    .Address             (Address),
    .Hit                 (Hit),
    .Hit_way             (Hit_way),
    .LRU_replacement_proc(LRU_replacement_proc),
    .Blk_accessed        (Blk_accessed),
    .Blk_access_valid    (Blk_access_valid),
    .CPU_stall           (CPU_stall),
    .Com_Bus_Req         (Com_Bus_Req),
    .Com_Bus_Gnt         (Com_Bus_Gnt),
    .Address_Com         (Address_Com),
    .Mem_Rd              (Mem_Rd),
    .Mem_ready           (Mem_ready),
    .Data_Bus_Com        (Data_Bus_Com),
    .Fill_we             (Fill_we),
    .Fill_way            (Fill_way),
    .Fill_addr           (Fill_addr),
    .Fill_data           (Fill_data),
    .Bus_error           (Bus_error)
  );

  // One record per clock cycle: inputs driven, then outputs expected before the next edge.
  typedef struct {
    logic          rst;
    logic          prrd;
    logic [AW-1:0] addr;
    logic          hit;
    logic [WW-1:0] hit_way;
    logic [WW-1:0] lru;
    logic          gnt;
    logic          rdy;
    logic [AW-1:0] dbus;
    logic [WW-1:0] e_blk;
    logic          e_blkv;
    logic          e_stall;
    logic          e_req;
    logic [AW-1:0] e_acom;
    logic          e_mrd;
    logic          e_we;
    logic [WW-1:0] e_fway;
    logic [AW-1:0] e_faddr;
    logic [AW-1:0] e_fdata;
    logic          e_berr;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_n                = !v.rst;
    PrRd                 = v.prrd;
    Address              = v.addr;
    Hit                  = v.hit;
    Hit_way              = v.hit_way;
    LRU_replacement_proc = v.lru;
    Com_Bus_Gnt          = v.gnt;
    Mem_ready            = v.rdy;
    Data_Bus_Com         = v.dbus;
  endtask

  // Drive at the falling edge, compare 1ns later, then move to the next falling edge.
  task automatic apply(input vec_t v, input string tag);
    drive(v);
    #1;
    check({tag, ".blk"},   AW'(Blk_accessed),     AW'(v.e_blk));
    check({tag, ".blkv"},  AW'(Blk_access_valid), AW'(v.e_blkv));
    check({tag, ".stall"}, AW'(CPU_stall),        AW'(v.e_stall));
    check({tag, ".req"},   AW'(Com_Bus_Req),      AW'(v.e_req));
    check({tag, ".acom"},  Address_Com,           v.e_acom);
    check({tag, ".mrd"},   AW'(Mem_Rd),           AW'(v.e_mrd));
    check({tag, ".we"},    AW'(Fill_we),          AW'(v.e_we));
    check({tag, ".fway"},  AW'(Fill_way),         AW'(v.e_fway));
    check({tag, ".faddr"}, Fill_addr,             v.e_faddr);
    check({tag, ".fdata"}, Fill_data,             v.e_fdata);
    check({tag, ".berr"},  AW'(Bus_error),        AW'(v.e_berr));
    @(negedge clk);
  endtask

  initial begin
    vec_t v;

    // Hit, basic miss with immediate grant/data, then a miss with victim and address churn.
    tbl[0]  = '{default: 0};
    tbl[1]  = '{default: 0, prrd: 1, hit: 1, hit_way: 2, e_blk: 2, e_blkv: 1};
    tbl[2]  = '{default: 0, hit: 1, hit_way: 1};
    tbl[3]  = '{default: 0, prrd: 1, addr: 32'h0000_1234, lru: 3, e_stall: 1};
    tbl[4]  = '{default: 0, gnt: 1, lru: 1, e_stall: 1, e_req: 1};
    tbl[5]  = '{default: 0, gnt: 1, rdy: 1, dbus: 32'hDEAD_BEEF, e_stall: 1, e_req: 1,
                e_mrd: 1, e_acom: 32'h0000_1234};
    tbl[6]  = '{default: 0, e_stall: 1, e_we: 1, e_fway: 3, e_faddr: 32'h0000_1234,
                e_fdata: 32'hDEAD_BEEF};
    tbl[7]  = '{default: 0, e_blk: 3, e_blkv: 1};
    tbl[8]  = '{default: 0, prrd: 1, hit: 1, hit_way: 3, e_blk: 3, e_blkv: 1};
    tbl[9]  = '{default: 0, prrd: 1, addr: 32'h0000_ABCF, lru: 1, e_stall: 1};
    tbl[10] = '{default: 0, addr: 32'hFFFF_0000, lru: 0, gnt: 1, e_stall: 1, e_req: 1};
    tbl[11] = '{default: 0, prrd: 1, addr: 32'h5555_5555, lru: 0, rdy: 1,
                dbus: 32'h1234_5678, e_stall: 1, e_req: 1, e_mrd: 1, e_acom: 32'h0000_ABCC};
    tbl[12] = '{default: 0, lru: 0, e_stall: 1, e_we: 1, e_fway: 1, e_faddr: 32'h0000_ABCF,
                e_fdata: 32'h1234_5678};
    tbl[13] = '{default: 0, e_blk: 1, e_blkv: 1};
    tbl[14] = '{default: 0};

    v = '{default: 0};
    v.rst = 1'b1;
    drive(v);
    repeat (2) @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < NV; i++) apply(tbl[i], $sformatf("row%0d", i));

    // Grant held low for five ARB cycles.
    apply('{default: 0, prrd: 1, addr: 32'h0000_2000, lru: 2, e_stall: 1}, "gd_miss");
    for (int k = 0; k < 5; k++)
      apply('{default: 0, e_stall: 1, e_req: 1}, $sformatf("gd_arb%0d", k));
    apply('{default: 0, gnt: 1, e_stall: 1, e_req: 1}, "gd_gnt");
    apply('{default: 0, rdy: 1, dbus: 32'hA5A5_0001, e_stall: 1, e_req: 1, e_mrd: 1,
            e_acom: 32'h0000_2000}, "gd_rd");
    apply('{default: 0, e_stall: 1, e_we: 1, e_fway: 2, e_faddr: 32'h0000_2000,
            e_fdata: 32'hA5A5_0001}, "gd_fill");
    apply('{default: 0, e_blk: 2, e_blkv: 1}, "gd_done");

    // No Mem_ready: error pulse on the 8th RD cycle, then IDLE with no fill.
    apply('{default: 0, prrd: 1, addr: 32'h0000_3006, lru: 1, e_stall: 1}, "to_miss");
    apply('{default: 0, gnt: 1, e_stall: 1, e_req: 1}, "to_arb");
    for (int k = 1; k <= TO; k++) begin
      v = '{default: 0, e_stall: 1, e_req: 1, e_mrd: 1, e_acom: 32'h0000_3004};
      v.e_berr = (k == TO);
      apply(v, $sformatf("to_rd%0d", k));
    end
    apply('{default: 0}, "to_idle");

    // Mem_ready on exactly the 8th RD cycle wins over the timeout.
    apply('{default: 0, prrd: 1, addr: 32'h0000_3006, lru: 1, e_stall: 1}, "tb_miss");
    apply('{default: 0, gnt: 1, e_stall: 1, e_req: 1}, "tb_arb");
    for (int k = 1; k <= TO; k++) begin
      v = '{default: 0, e_stall: 1, e_req: 1, e_mrd: 1, e_acom: 32'h0000_3004};
      v.rdy  = (k == TO);
      v.dbus = 32'hCAFE_F00D;
      apply(v, $sformatf("tb_rd%0d", k));
    end
    apply('{default: 0, e_stall: 1, e_we: 1, e_fway: 1, e_faddr: 32'h0000_3006,
            e_fdata: 32'hCAFE_F00D}, "tb_fill");
    apply('{default: 0, e_blk: 1, e_blkv: 1}, "tb_done");

    // Reset in the middle of RD, then a fresh miss latches the new victim.
    apply('{default: 0, prrd: 1, addr: 32'h0000_4000, lru: 2, e_stall: 1}, "rs_miss");
    apply('{default: 0, gnt: 1, e_stall: 1, e_req: 1}, "rs_arb");
    apply('{default: 0, e_stall: 1, e_req: 1, e_mrd: 1, e_acom: 32'h0000_4000}, "rs_rd");
    drive('{default: 0, rst: 1, lru: 2, gnt: 1, rdy: 1, dbus: 32'hBAD0_BAD0});
    @(negedge clk);
    apply('{default: 0}, "rs_after");
    apply('{default: 0, prrd: 1, addr: 32'h0000_5008, lru: 0, e_stall: 1}, "rs_miss2");
    apply('{default: 0, gnt: 1, e_stall: 1, e_req: 1}, "rs_arb2");
    apply('{default: 0, rdy: 1, dbus: 32'h0BAD_F00D, e_stall: 1, e_req: 1, e_mrd: 1,
            e_acom: 32'h0000_5008}, "rs_rd2");
    apply('{default: 0, e_stall: 1, e_we: 1, e_fway: 0, e_faddr: 32'h0000_5008,
            e_fdata: 32'h0BAD_F00D}, "rs_fill2");
    apply('{default: 0, e_blk: 0, e_blkv: 1}, "rs_done2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
